// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand-entry front-end.
//   entry_state_t : operand-entry FSM states, encoded as driven onto the LED port
//   CALC_WIDTH    : default operand width of the downstream calculator
package calc_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        SHOW   = 2'd3
    } entry_state_t;

    localparam int CALC_WIDTH = 4;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability-count debouncer and
// rising-edge pulse generator.
// Ports:
//   clk   in  system clock
//   clr   in  synchronous active-high reset
//   btn   in  raw asynchronous bouncing button
//   press out one-cycle pulse, one cycle after the debounced level rises
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_r;
    logic             btn_sync_r;
    logic             level_r;
    logic             level_d_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-flop synchronizer bringing the asynchronous button into the clk domain
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_r    <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            sync1_r    <= btn;
            btn_sync_r <= sync1_r;
        end
    end

    // Debounce counter: any cycle of agreement restarts the count, so a
    // level change needs DB_CYCLES consecutive cycles of disagreement
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
        end else if (btn_sync_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= {CNT_W{1'b0}};
                level_r <= ~level_r;
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Rising-edge detect on the debounced level; releases produce no pulse
    always_ff @(posedge clk) begin
        if (clr) begin
            level_d_r <= 1'b0;
            press     <= 1'b0;
        end else begin
            level_d_r <= level_r;
            press     <= level_r & ~level_d_r;
        end
    end

endmodule

// File: rtl/calc_entry_seq.sv
// Operand-entry sequencer for the 4-bit add/subtract calculator.
// One debounced button steps through: capture A, capture B/Sub/RC, strobe en
// for one cycle, then show the result until the next press starts a new entry.
// Ports:
//   clk, clr         clock and synchronous active-high reset
//   btn              raw pushbutton
//   sw, sub_sw, rc_sw operand / subtract / signed-select switches
//   A, B, Sub, RC    registered calculator inputs
//   en               one-cycle calculator load strobe (high while in EXEC)
//   state            current FSM state for LEDs
// Build option: define CALC_ENTRY_TIMEOUT_EN to abandon an entry left idle in
// LOAD_B for TIMEOUT_CYCLES cycles (back to LOAD_A with A cleared, no en).
module calc_entry_seq
    import calc_pkg::*;
#(
    parameter int WIDTH          = CALC_WIDTH,
    parameter int DB_CYCLES      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             btn,
    input  logic [WIDTH-1:0] sw,
    input  logic             sub_sw,
    input  logic             rc_sw,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Sub,
    output logic             RC,
    output logic             en,
    output logic [1:0]       state
);

    entry_state_t state_r;
    entry_state_t state_next_s;
    logic         press_s;
    logic         cap_a_s;
    logic         cap_b_s;
    logic         clr_a_s;
    logic         timeout_s;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn),
        .press (press_s)
    );

`ifdef CALC_ENTRY_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_r;

    // Idle counter: runs only while waiting in LOAD_B; it is zero on the first
    // LOAD_B cycle because it is held at zero in every other state
    always_ff @(posedge clk) begin
        if (clr) begin
            idle_r <= {IDLE_W{1'b0}};
        end else if ((state_r != LOAD_B) || press_s) begin
            idle_r <= {IDLE_W{1'b0}};
        end else begin
            idle_r <= idle_r + {{(IDLE_W-1){1'b0}}, 1'b1};
        end
    end

    assign timeout_s = (state_r == LOAD_B) && (idle_r == IDLE_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and capture decode; a press always beats a coincident timeout
    always_comb begin
        state_next_s = state_r;
        cap_a_s      = 1'b0;
        cap_b_s      = 1'b0;
        clr_a_s      = 1'b0;
        case (state_r)
            LOAD_A: begin
                if (press_s) begin
                    cap_a_s      = 1'b1;
                    state_next_s = LOAD_B;
                end else begin
                    state_next_s = LOAD_A;
                end
            end
            LOAD_B: begin
                if (press_s) begin
                    cap_b_s      = 1'b1;
                    state_next_s = EXEC;
                end else if (timeout_s) begin
                    clr_a_s      = 1'b1;
                    state_next_s = LOAD_A;
                end else begin
                    state_next_s = LOAD_B;
                end
            end
            EXEC: begin
                state_next_s = SHOW;
            end
            SHOW: begin
                if (press_s) begin
                    cap_a_s      = 1'b1;
                    state_next_s = LOAD_B;
                end else begin
                    state_next_s = SHOW;
                end
            end
            default: begin
                state_next_s = LOAD_A;
            end
        endcase
    end

    // State register; en is registered from the next state so it is high
    // exactly while the state register holds EXEC
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= LOAD_A;
            en      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            en      <= (state_next_s == EXEC);
        end
    end

    // Operand registers: switches are only sampled on a capturing press
    always_ff @(posedge clk) begin
        if (clr) begin
            A   <= {WIDTH{1'b0}};
            B   <= {WIDTH{1'b0}};
            Sub <= 1'b0;
            RC  <= 1'b0;
        end else begin
            if (cap_a_s) begin
                A <= sw;
            end else if (clr_a_s) begin
                A <= {WIDTH{1'b0}};
            end
            if (cap_b_s) begin
                B   <= sw;
                Sub <= sub_sw;
                RC  <= rc_sw;
            end
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_calc_entry_seq.sv
module tb_calc_entry_seq;

`ifdef CALC_ENTRY_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 1024;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       btn = 1'b0;
    logic [3:0] sw = 4'd0;
    logic       sub_sw = 1'b0;
    logic       rc_sw = 1'b0;
    logic [3:0] A;
    logic [3:0] B;
    logic       Sub;
    logic       RC;
    logic       en;
    logic [1:0] state;

    int total = 0;
    int bad = 0;
    int en_cnt = 0;
    logic [1:0] last_state = 2'd0;
    logic [1:0] trace[$];

    calc_entry_seq #(
        .WIDTH          (4),
        .DB_CYCLES      (4),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .btn    (btn),
        .sw     (sw),
        .sub_sw (sub_sw),
        .rc_sw  (rc_sw),
        .A      (A),
        .B      (B),
        .Sub    (Sub),
        .RC     (RC),
        .en     (en),
        .state  (state)
    );

    always #5 clk = ~clk;

    // Advance one cycle, observe just after the edge, log en pulses and state changes
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (en === 1'b1) en_cnt++;
            if (state !== last_state) begin
                trace.push_back(state);
                last_state = state;
            end
        end
    endtask

    task automatic pulse_btn(input int hold, input int rel);
        btn = 1'b1;
        tick(hold);
        btn = 1'b0;
        tick(rel);
    endtask

    task automatic do_reset();
        btn = 1'b0;
        clr = 1'b1;
        tick(2);
        clr = 1'b0;
        en_cnt = 0;
        trace.delete();
        last_state = 2'd0;
    endtask

    task automatic test_reset();
        sw = 4'hA; sub_sw = 1'b1; rc_sw = 1'b1;
        do_reset();
        total++;
        if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++;
        if ({A, B} !== 8'h00) begin bad++; $display("FAIL reset_operands: got A=%0h B=%0h want 0 0", A, B); end
        total++;
        if ({Sub, RC, en} !== 3'b000) begin bad++; $display("FAIL reset_flags: got Sub=%b RC=%b en=%b want 000", Sub, RC, en); end
    endtask

    task automatic test_clean_entry();
        do_reset();
        sw = 4'd3; sub_sw = 1'b0; rc_sw = 1'b0;
        btn = 1'b1;
        tick(7);
        total++;
        if (state !== 2'd0) begin bad++; $display("FAIL latency_early: got state=%0d want 0", state); end
        tick(1);
        total++;
        if (state !== 2'd1 || A !== 4'd3) begin bad++; $display("FAIL capture_a: got state=%0d A=%0d want 1 3", state, A); end
        tick(2);
        btn = 1'b0;
        tick(10);
        sw = 4'd5; sub_sw = 1'b1; rc_sw = 1'b1;
        btn = 1'b1;
        tick(8);
        total++;
        if (state !== 2'd2 || en !== 1'b1) begin bad++; $display("FAIL exec_strobe: got state=%0d en=%b want 2 1", state, en); end
        total++;
        if ({A, B, Sub, RC} !== {4'd3, 4'd5, 1'b1, 1'b1}) begin
            bad++; $display("FAIL exec_operands: got A=%0d B=%0d Sub=%b RC=%b want 3 5 1 1", A, B, Sub, RC);
        end
        tick(1);
        total++;
        if (state !== 2'd3 || en !== 1'b0) begin bad++; $display("FAIL show_state: got state=%0d en=%b want 3 0", state, en); end
        tick(1);
        btn = 1'b0;
        sw = 4'd0; sub_sw = 1'b0; rc_sw = 1'b0;
        tick(10);
        total++;
        if (en_cnt !== 1) begin bad++; $display("FAIL en_count: got %0d want 1", en_cnt); end
        total++;
        if (trace.size() != 3 || trace[0] !== 2'd1 || trace[1] !== 2'd2 || trace[2] !== 2'd3) begin
            bad++; $display("FAIL state_sequence: got %0d states want 1,2,3 after 0", trace.size());
        end
        total++;
        if ({A, B, Sub, RC, state} !== {4'd3, 4'd5, 1'b1, 1'b1, 2'd3}) begin
            bad++; $display("FAIL show_hold: got A=%0d B=%0d Sub=%b RC=%b state=%0d want 3 5 1 1 3", A, B, Sub, RC, state);
        end
    endtask

    task automatic test_restart_from_show();
        en_cnt = 0;
        sw = 4'hF;
        pulse_btn(10, 10);
        total++;
        if ({A, state} !== {4'hF, 2'd1}) begin bad++; $display("FAIL restart: got A=%0h state=%0d want f 1", A, state); end
        total++;
        if (B !== 4'd5 || en_cnt !== 0) begin bad++; $display("FAIL restart_hold: got B=%0d en_cnt=%0d want 5 0", B, en_cnt); end
    endtask

    task automatic test_bounce();
        do_reset();
        sw = 4'd4;
        btn = 1'b1; tick(1);
        btn = 1'b0; tick(1);
        btn = 1'b1; tick(1);
        btn = 1'b0; tick(1);
        btn = 1'b1;
        tick(7);
        total++;
        if (state !== 2'd0) begin bad++; $display("FAIL bounce_early: got state=%0d want 0", state); end
        tick(1);
        total++;
        if (state !== 2'd1 || A !== 4'd4) begin bad++; $display("FAIL bounce_press: got state=%0d A=%0d want 1 4", state, A); end
        tick(2);
        btn = 1'b0;
        tick(10);
        total++;
        if (state !== 2'd1 || en_cnt !== 0) begin bad++; $display("FAIL bounce_single: got state=%0d en_cnt=%0d want 1 0", state, en_cnt); end
    endtask

    task automatic test_held();
        do_reset();
        sw = 4'd8;
        pulse_btn(100, 10);
        total++;
        if ({state, A} !== {2'd1, 4'd8} || en_cnt !== 0) begin
            bad++; $display("FAIL held: got state=%0d A=%0d en_cnt=%0d want 1 8 0", state, A, en_cnt);
        end
    endtask

    task automatic test_reset_mid_entry();
        do_reset();
        sw = 4'd9;
        pulse_btn(10, 10);
        total++;
        if ({state, A} !== {2'd1, 4'd9}) begin bad++; $display("FAIL pre_clr: got state=%0d A=%0d want 1 9", state, A); end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        total++;
        if ({state, A, en} !== {2'd0, 4'd0, 1'b0}) begin
            bad++; $display("FAIL clr_load_b: got state=%0d A=%0d en=%b want 0 0 0", state, A, en);
        end
        en_cnt = 0;
        sw = 4'd2; pulse_btn(10, 10);
        sw = 4'd7; sub_sw = 1'b0; rc_sw = 1'b0; pulse_btn(10, 10);
        total++;
        if ({A, B, Sub, RC, state} !== {4'd2, 4'd7, 1'b0, 1'b0, 2'd3} || en_cnt !== 1) begin
            bad++; $display("FAIL after_clr_entry: got A=%0d B=%0d state=%0d en_cnt=%0d want 2 7 3 1", A, B, state, en_cnt);
        end
        // clr while en is high
        sw = 4'd1; pulse_btn(10, 10);
        sw = 4'd6; btn = 1'b1;
        tick(8);
        total++;
        if (state !== 2'd2) begin bad++; $display("FAIL reach_exec: got state=%0d want 2", state); end
        clr = 1'b1; btn = 1'b0;
        tick(1);
        clr = 1'b0;
        total++;
        if ({state, A, B, en} !== {2'd0, 4'd0, 4'd0, 1'b0}) begin
            bad++; $display("FAIL clr_exec: got state=%0d A=%0d B=%0d en=%b want 0 0 0 0", state, A, B, en);
        end
        // clr coincident with the press pulse: nothing captured
        tick(10);
        sw = 4'hC; btn = 1'b1;
        tick(7);
        clr = 1'b1; btn = 1'b0;
        tick(1);
        clr = 1'b0;
        tick(10);
        total++;
        if ({state, A} !== {2'd0, 4'd0}) begin bad++; $display("FAIL clr_with_press: got state=%0d A=%0d want 0 0", state, A); end
    endtask

    task automatic test_idle_wait();
        do_reset();
        sw = 4'd6;
        pulse_btn(10, 40);
        total++;
        if ({state, A} !== {2'd1, 4'd6} || en_cnt !== 0) begin
            bad++; $display("FAIL idle_wait: got state=%0d A=%0d en_cnt=%0d want 1 6 0", state, A, en_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        sw = 4'd6;
        btn = 1'b1;
        tick(8);
        total++;
        if ({state, A} !== {2'd1, 4'd6}) begin bad++; $display("FAIL to_enter: got state=%0d A=%0d want 1 6", state, A); end
        tick(7);
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL to_early: got state=%0d want 1", state); end
        tick(1);
        total++;
        if ({state, A} !== {2'd0, 4'd0} || en_cnt !== 0) begin
            bad++; $display("FAIL timeout: got state=%0d A=%0d en_cnt=%0d want 0 0 0", state, A, en_cnt);
        end
        btn = 1'b0;
        tick(10);
    endtask

    initial begin
        test_reset();
`ifdef CALC_ENTRY_TIMEOUT_EN
        test_timeout();
`else
        test_clean_entry();
        test_restart_from_show();
        test_bounce();
        test_held();
        test_reset_mid_entry();
        test_idle_wait();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
